// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Shared command-word layout, opcodes and logic-grid constants
//               for the snake draw-command producer and renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    localparam int GRID_H_WIDTH = 5;
    localparam int GRID_V_WIDTH = 5;
    localparam int GRID_H_MAX   = 31;
    localparam int GRID_V_MAX   = 23;
    localparam int COLOR_WIDTH  = 8;

    localparam int CMD_WIDTH = 4 + 2 * (GRID_H_WIDTH + GRID_V_WIDTH) + COLOR_WIDTH;

    localparam logic [3:0] OP_CELL = 4'h0;
    localparam logic [3:0] OP_FILL = 4'h1;

    // Both formats share opcode, first x and first y; the rest packs downward.
    localparam int OP_LSB         = CMD_WIDTH - 4;
    localparam int F_X0_LSB       = OP_LSB - GRID_H_WIDTH;
    localparam int F_Y0_LSB       = F_X0_LSB - GRID_V_WIDTH;
    localparam int CELL_COLOR_LSB = F_Y0_LSB - COLOR_WIDTH;
    localparam int FILL_X1_LSB    = F_Y0_LSB - GRID_H_WIDTH;
    localparam int FILL_Y1_LSB    = FILL_X1_LSB - GRID_V_WIDTH;
    localparam int FILL_COLOR_LSB = 0;

    function automatic logic [3:0] cmd_opcode(input logic [CMD_WIDTH-1:0] cmd);
        return cmd[OP_LSB +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : snake_cmd_fifo
// Description : Synchronous command FIFO with registered occupancy level.
//               A push into a full FIFO only succeeds alongside a pop.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_cmd_fifo #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   pop_data,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   level
);

    localparam logic [FIFO_AW:0] c_full_level = FIFO_DEPTH[FIFO_AW:0];

    logic [WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_level == c_full_level);
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/snake_cmd_render.sv
`default_nettype none
// ============================================================================
// Module      : snake_cmd_render
// Description : Buffers snake draw commands and turns CELL/FILL commands into
//               per-cell tile-RAM colour writes. SNAKE_RENDER_STATS_EN adds
//               saturating cells_written / cmds_dropped counters.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_cmd_render
    import snake_pkg::*;
#(
    parameter int H_LOGIC_WIDTH  = GRID_H_WIDTH,
    parameter int V_LOGIC_WIDTH  = GRID_V_WIDTH,
    parameter int H_LOGIC_MAX    = GRID_H_MAX,
    parameter int V_LOGIC_MAX    = GRID_V_MAX,
    parameter int COLOR_ID_WIDTH = COLOR_WIDTH,
    parameter int FIFO_DEPTH     = 8,
    parameter int FIFO_AW        = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [CMD_WIDTH-1:0]                   cmd_in,
    input  logic                                   cmd_vld_in,
    output logic                                   wr_en,
    output logic [V_LOGIC_WIDTH+H_LOGIC_WIDTH-1:0] wr_addr,
    output logic [COLOR_ID_WIDTH-1:0]              wr_data,
    output logic                                   busy,
    output logic [FIFO_AW:0]                       fifo_level,
    output logic                                   overflow,
    output logic                                   bad_cmd
`ifdef SNAKE_RENDER_STATS_EN
    ,
    output logic [15:0]                            cells_written,
    output logic [15:0]                            cmds_dropped
`endif
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_write1 = 2'd1;
    localparam logic [1:0] c_st_fill   = 2'd2;

    localparam logic [H_LOGIC_WIDTH-1:0] c_h_max   = H_LOGIC_MAX[H_LOGIC_WIDTH-1:0];
    localparam logic [V_LOGIC_WIDTH-1:0] c_v_max   = V_LOGIC_MAX[V_LOGIC_WIDTH-1:0];
    localparam logic [FIFO_AW:0]         c_lvl_one = (FIFO_AW + 1)'(1);

    logic [CMD_WIDTH-1:0]      r_prev_cmd;
    logic                      r_prev_vld;
    logic                      w_push_req;
    logic                      w_push_ok;
    logic                      w_drop;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic [CMD_WIDTH-1:0]      w_head;

    logic [3:0]                w_op;
    logic [H_LOGIC_WIDTH-1:0]  w_hx;
    logic [H_LOGIC_WIDTH-1:0]  w_hx1;
    logic [H_LOGIC_WIDTH-1:0]  w_hx1c;
    logic [V_LOGIC_WIDTH-1:0]  w_hy;
    logic [V_LOGIC_WIDTH-1:0]  w_hy1;
    logic [V_LOGIC_WIDTH-1:0]  w_hy1c;
    logic                      w_cell_ok;

    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic [H_LOGIC_WIDTH-1:0]  r_x;
    logic [H_LOGIC_WIDTH-1:0]  r_x_start;
    logic [H_LOGIC_WIDTH-1:0]  r_x_end;
    logic [V_LOGIC_WIDTH-1:0]  r_y;
    logic [V_LOGIC_WIDTH-1:0]  r_y_end;
    logic [COLOR_ID_WIDTH-1:0] r_color;
    logic                      w_fill_empty;
    logic                      w_fill_last;
    logic                      w_fifo_left;
    logic                      w_wr_en_next;
    logic                      w_bad_next;
    logic                      w_busy_next;

    // A word held valid across consecutive cycles is the same command repeated.
    assign w_push_req = cmd_vld_in && !(r_prev_vld && (cmd_in == r_prev_cmd));
    assign w_pop      = (r_state == c_st_idle) && !w_empty;
    assign w_push_ok  = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    snake_cmd_fifo #(
        .WIDTH      (CMD_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push_req),
        .push_data (cmd_in),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (fifo_level)
    );

    assign w_op      = cmd_opcode(w_head);
    assign w_hx      = w_head[F_X0_LSB +: H_LOGIC_WIDTH];
    assign w_hy      = w_head[F_Y0_LSB +: V_LOGIC_WIDTH];
    assign w_hx1     = w_head[FILL_X1_LSB +: H_LOGIC_WIDTH];
    assign w_hy1     = w_head[FILL_Y1_LSB +: V_LOGIC_WIDTH];
    assign w_hx1c    = (w_hx1 > c_h_max) ? c_h_max : w_hx1;
    assign w_hy1c    = (w_hy1 > c_v_max) ? c_v_max : w_hy1;
    assign w_cell_ok = (w_hx <= c_h_max) && (w_hy <= c_v_max);

    assign w_fill_empty = (r_x_start > r_x_end) || (r_y > r_y_end);
    assign w_fill_last  = (r_x == r_x_end) && (r_y == r_y_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            c_st_idle: begin
                if (!w_empty) begin
                    if (w_op == OP_FILL) begin
                        w_state_next = c_st_fill;
                    end else if ((w_op == OP_CELL) && w_cell_ok) begin
                        w_state_next = c_st_write1;
                    end
                end
            end
            c_st_write1: w_state_next = c_st_idle;
            c_st_fill: begin
                if (w_fill_empty || w_fill_last) begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_wr_en_next = (r_state == c_st_write1) ||
                       ((r_state == c_st_fill) && !w_fill_empty);
        w_bad_next   = w_pop && (w_op != OP_FILL) &&
                       ((w_op != OP_CELL) || !w_cell_ok);
        w_fifo_left  = !w_empty && !(w_pop && (fifo_level == c_lvl_one));
        w_busy_next  = (w_state_next != c_st_idle) || w_push_ok ||
                       w_fifo_left || w_wr_en_next;
    end

    // Scan cursor: loaded on pop, then walks the clipped rectangle x-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_x_start <= '0;
            r_x_end   <= '0;
            r_y_end   <= '0;
            r_color   <= '0;
        end else if (w_pop) begin
            r_x       <= w_hx;
            r_y       <= w_hy;
            r_x_start <= w_hx;
            r_x_end   <= w_hx1c;
            r_y_end   <= w_hy1c;
            r_color   <= (w_op == OP_FILL) ? w_head[FILL_COLOR_LSB +: COLOR_ID_WIDTH]
                                           : w_head[CELL_COLOR_LSB +: COLOR_ID_WIDTH];
        end else if ((r_state == c_st_fill) && !w_fill_empty && !w_fill_last) begin
            if (r_x == r_x_end) begin
                r_x <= r_x_start;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            bad_cmd    <= 1'b0;
            r_prev_vld <= 1'b0;
            r_prev_cmd <= '0;
        end else begin
            wr_en      <= w_wr_en_next;
            wr_addr    <= {r_y, r_x};
            wr_data    <= r_color;
            busy       <= w_busy_next;
            r_prev_vld <= cmd_vld_in;
            r_prev_cmd <= cmd_in;
            if (w_drop) begin
                overflow <= 1'b1;
            end
            if (w_bad_next) begin
                bad_cmd <= 1'b1;
            end
        end
    end

`ifdef SNAKE_RENDER_STATS_EN
    logic [15:0] r_cells_written;
    logic [15:0] r_cmds_dropped;
    logic [1:0]  w_drop_inc;
    logic [16:0] w_drop_sum;

    assign w_drop_inc = {1'b0, w_drop} + {1'b0, w_bad_next};
    assign w_drop_sum = {1'b0, r_cmds_dropped} + {15'd0, w_drop_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cells_written <= '0;
            r_cmds_dropped  <= '0;
        end else begin
            if (w_wr_en_next && (r_cells_written != 16'hFFFF)) begin
                r_cells_written <= r_cells_written + 16'd1;
            end
            r_cmds_dropped <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign cells_written = r_cells_written;
    assign cmds_dropped  = r_cmds_dropped;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_snake_cmd_render.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_cmd_render
// Description : Self-checking bench for snake_cmd_render against a
//               command-level reference model of the expected write stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_cmd_render;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd_in;
    logic        cmd_vld_in;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        bad_cmd;
`ifdef SNAKE_RENDER_STATS_EN
    logic [15:0] cells_written;
    logic [15:0] cmds_dropped;
`endif

    always #5 clk = ~clk;

    snake_cmd_render dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_in     (cmd_in),
        .cmd_vld_in (cmd_vld_in),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .bad_cmd    (bad_cmd)
`ifdef SNAKE_RENDER_STATS_EN
        ,
        .cells_written (cells_written),
        .cmds_dropped  (cmds_dropped)
`endif
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [17:0] obs_q[$];
    int          obs_cyc[$];
    logic [17:0] exp_q[$];
    bit          exp_bad;
    bit          exp_ovf;
    int          exp_cells;
    int          exp_drops;
    int          peak_level;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && wr_en) begin
            obs_q.push_back({wr_addr, wr_data});
            obs_cyc.push_back(cyc);
        end
        if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_cell(input int x, input int y, input int col);
        logic [4:0] xs, ys;
        logic [7:0] cs;
        xs = x[4:0]; ys = y[4:0]; cs = col[7:0];
        return {4'h0, xs, ys, cs, 10'd0};
    endfunction

    function automatic logic [31:0] mk_fill(input int x0, input int y0, input int x1,
                                            input int y1, input int col);
        logic [4:0] a, b, c, d;
        logic [7:0] cs;
        a = x0[4:0]; b = y0[4:0]; c = x1[4:0]; d = y1[4:0]; cs = col[7:0];
        return {4'h1, a, b, c, d, cs};
    endfunction

    // Reference: which cells a command paints, from the command-format rules.
    task automatic expand(input logic [31:0] c);
        int op, x0, y0, x1, y1, col, x1c, y1c;
        op = int'(c[31:28]);
        x0 = int'(c[27:23]);
        y0 = int'(c[22:18]);
        if (op == 0) begin
            col = int'(c[17:10]);
            if (x0 > 31 || y0 > 23) begin
                exp_bad = 1; exp_drops++;
            end else begin
                exp_q.push_back(18'((y0 * 32 + x0) * 256 + col));
                exp_cells++;
            end
        end else if (op == 1) begin
            x1  = int'(c[17:13]);
            y1  = int'(c[12:8]);
            col = int'(c[7:0]);
            x1c = (x1 > 31) ? 31 : x1;
            y1c = (y1 > 23) ? 23 : y1;
            for (int yy = y0; yy <= y1c; yy++) begin
                for (int xx = x0; xx <= x1c; xx++) begin
                    exp_q.push_back(18'((yy * 32 + xx) * 256 + col));
                    exp_cells++;
                end
            end
        end else begin
            exp_bad = 1; exp_drops++;
        end
    endtask

    task automatic clear_model();
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        exp_bad = 0; exp_ovf = 0; exp_cells = 0; exp_drops = 0; peak_level = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cmd_vld_in = 1'b0; cmd_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic send(input logic [31:0] w, input int hold, output int acc);
        @(negedge clk);
        cmd_in = w; cmd_vld_in = 1'b1; acc = cyc + 1;
        repeat (hold) @(negedge clk);
        cmd_vld_in = 1'b0;
    endtask

    task automatic send_burst(input logic [31:0] ws[$], output int acc0);
        acc0 = 0;
        foreach (ws[i]) begin
            @(negedge clk);
            cmd_in = ws[i]; cmd_vld_in = 1'b1;
            if (i == 0) acc0 = cyc + 1;
        end
        @(negedge clk);
        cmd_vld_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check_eq({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq({tag, "_wr"}, 32'(obs_q[i]), 32'(exp_q[i]));
        check_eq({tag, "_bad"}, 32'(bad_cmd), 32'(exp_bad));
        check_eq({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        check_eq({tag, "_lvl"}, 32'(fifo_level), 32'd0);
`ifdef SNAKE_RENDER_STATS_EN
        check_eq({tag, "_cells"}, 32'(cells_written), 32'(exp_cells));
        check_eq({tag, "_drops"}, 32'(cmds_dropped), 32'(exp_drops));
`endif
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    endtask

    function automatic logic [31:0] gen_rand();
        int sel, x0, y0, x1, y1;
        logic [31:0] w;
        logic [3:0]  op;
        sel = $urandom_range(0, 9);
        x0  = $urandom_range(0, 31);
        y0  = $urandom_range(0, 23);
        if (sel <= 3) begin
            w = mk_cell(x0, y0, $urandom_range(0, 255));
        end else if (sel == 4) begin
            w = mk_cell(x0, $urandom_range(24, 31), $urandom_range(0, 255));
        end else if (sel <= 6) begin
            x1 = x0 + $urandom_range(0, 3); if (x1 > 31) x1 = 31;
            y1 = y0 + $urandom_range(0, 3); if (y1 > 31) y1 = 31;
            if (sel == 6 && x0 > 0) x1 = x0 - 1;
            w = mk_fill(x0, y0, x1, y1, $urandom_range(0, 255));
        end else if (sel == 7) begin
            w = mk_fill($urandom_range(28, 31), $urandom_range(20, 23), 31,
                        $urandom_range(23, 31), $urandom_range(0, 255));
        end else begin
            op = 4'($urandom_range(2, 15));
            w  = {op, 28'($urandom)};
        end
        return w;
    endfunction

    initial begin
        int          acc;
        logic [31:0] w;
        logic [31:0] ws[$];
        int          cnt_at_rst;

        rst = 1'b1; cmd_in = '0; cmd_vld_in = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_wr_en", 32'(wr_en), 0);
        check_eq("rst_level", 32'(fifo_level), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_ovf", 32'(overflow), 0);
        check_eq("rst_bad", 32'(bad_cmd), 0);

        // Out-of-range cell, then a single in-range cell with latency check.
        do_reset();
        w = mk_cell(31, 30, 8'h0F);
        expand(w);
        send(w, 1, acc);
        wait_idle("cell_oor", 20);
        compare_writes("cell_oor");

        do_reset();
        w = mk_cell(3, 5, 8'h0F);
        expand(w);
        send(w, 1, acc);
        while (!wr_en && cyc < acc + 10) @(negedge clk);
        check_eq("cell_lat", 32'(cyc), 32'(acc + 2));
        check_eq("cell_addr", 32'(wr_addr), 32'h0A3);
        check_eq("cell_data", 32'(wr_data), 32'h0F);
        check_eq("cell_busy_on", 32'(busy), 1);
        @(negedge clk);
        check_eq("cell_busy_off", 32'(busy), 0);
        compare_writes("cell");

        // Full-screen fill held valid for 10 cycles.
        do_reset();
        w = mk_fill(0, 0, 31, 23, 8'hFF);
        expand(w);
        send(w, 10, acc);
        wait_idle("fill", 2000);
        if (obs_cyc.size() == 768) begin
            check_eq("fill_lat", 32'(obs_cyc[0]), 32'(acc + 2));
            check_eq("fill_span", 32'(obs_cyc[767] - obs_cyc[0]), 767);
        end
        compare_writes("fill");

        // Three-word burst on consecutive cycles.
        do_reset();
        ws = '{mk_cell(10, 10, 8'h0F), mk_cell(9, 10, 8'hFF), mk_cell(20, 4, 8'hE0)};
        foreach (ws[i]) expand(ws[i]);
        send_burst(ws, acc);
        wait_idle("burst", 50);
        if (obs_cyc.size() == 3) begin
            check_eq("burst_lat", 32'(obs_cyc[0]), 32'(acc + 2));
            check_eq("burst_gap1", 32'(obs_cyc[1] - obs_cyc[0]), 2);
            check_eq("burst_gap2", 32'(obs_cyc[2] - obs_cyc[1]), 2);
        end
        check_eq("burst_peak", 32'(peak_level >= 2 && peak_level <= 3), 1);
        compare_writes("burst");

        // Overflow: nine distinct cells pushed behind a long fill.
        do_reset();
        w = mk_fill(0, 0, 31, 23, 8'h5A);
        expand(w);
        send(w, 1, acc);
        repeat (5) @(negedge clk);
        ws.delete();
        for (int i = 0; i < 9; i++) ws.push_back(mk_cell(i + 1, i, 16 + i));
        for (int i = 0; i < 8; i++) expand(ws[i]);
        exp_ovf = 1; exp_drops++;
        send_burst(ws, acc);
        check_eq("ovf_level", 32'(fifo_level), 8);
        check_eq("ovf_flag", 32'(overflow), 1);
        wait_idle("ovf", 2000);
        compare_writes("ovf");

        // Inverted fill, clipped fill, re-armed repeat, unknown opcode.
        do_reset();
        w = mk_fill(5, 0, 2, 0, 8'h33);
        expand(w);
        send(w, 1, acc);
        wait_idle("inv", 20);
        compare_writes("inv");
        w = mk_fill(30, 22, 31, 31, 8'h44);
        expand(w);
        send(w, 1, acc);
        wait_idle("clip", 20);
        compare_writes("clip");
        w = mk_cell(7, 7, 8'h21);
        expand(w); expand(w);
        send(w, 1, acc);
        send(w, 1, acc);
        wait_idle("rearm", 20);
        compare_writes("rearm");
        w = {4'h7, 28'h1234567};
        expand(w);
        send(w, 1, acc);
        wait_idle("badop", 20);
        compare_writes("badop");

        // Reset in the middle of a fill with flags and queue populated.
        do_reset();
        send({4'h9, 28'h0}, 1, acc);
        send(mk_fill(0, 0, 31, 23, 8'h11), 1, acc);
        send(mk_cell(1, 1, 1), 1, acc);
        send(mk_cell(2, 2, 2), 1, acc);
        begin
            int n;
            n = 0;
            while (obs_q.size() < 100 && n < 2000) begin
                @(negedge clk); #1; n++;
            end
        end
        check_eq("pre_rst_writes", 32'(obs_q.size()), 100);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_wr_en", 32'(wr_en), 0);
        check_eq("mid_rst_level", 32'(fifo_level), 0);
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_bad", 32'(bad_cmd), 0);
        check_eq("mid_rst_ovf", 32'(overflow), 0);
`ifdef SNAKE_RENDER_STATS_EN
        check_eq("mid_rst_cells", 32'(cells_written), 0);
        check_eq("mid_rst_drops", 32'(cmds_dropped), 0);
`endif
        rst = 1'b0;
        cnt_at_rst = obs_q.size();
        repeat (20) @(negedge clk);
        check_eq("post_rst_writes", 32'(obs_q.size()), 32'(cnt_at_rst));
        check_eq("post_rst_busy", 32'(busy), 0);

        // Randomized single commands and short bursts.
        do_reset();
        for (int it = 0; it < 40; it++) begin
            int k;
            k = $urandom_range(1, 3);
            ws.delete();
            for (int j = 0; j < k; j++) begin
                w = gen_rand();
                while (j > 0 && w == ws[j - 1]) w = gen_rand();
                ws.push_back(w);
                expand(w);
            end
            if (k == 1) begin
                send(ws[0], $urandom_range(1, 4), acc);
                wait_idle("rnd", 100);
                if (exp_q.size() > 0 && obs_cyc.size() > 0)
                    check_eq("rnd_lat", 32'(obs_cyc[0]), 32'(acc + 2));
            end else begin
                send_burst(ws, acc);
                wait_idle("rnd_burst", 200);
            end
            compare_writes("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
